// File: rtl/ascon_pack.sv
// Shared types and helpers for the ASCON permutation core:
// state type, round constants, round-count encoding and controller states.
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    localparam logic [1:0] P12 = 2'b00;
    localparam logic [1:0] P8  = 2'b01;
    localparam logic [1:0] P6  = 2'b10;

    localparam logic [3:0] LAST_RND = 4'd12;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {~r, r};
    endfunction

    // 2'b11 is deliberately folded onto p^12
    function automatic logic [3:0] first_round(input logic [1:0] nb);
        case (nb)
            P8:      return 4'd4;
            P6:      return 4'd6;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One ASCON round: constant addition into x2, 5-bit S-box layer, linear diffusion.
module ascon_round
    import ascon_pack::*;
(
    input  type_state  state_i,
    input  logic [3:0] round_i,
    output type_state  state_o
);

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;

    always_comb begin
        x0 = state_i[0];
        x1 = state_i[1];
        x2 = state_i[2] ^ {56'h0, round_const(round_i)};
        x3 = state_i[3];
        x4 = state_i[4];

        // bitsliced S-box, same sequence as the reference C implementation
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        state_o[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        state_o[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        state_o[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        state_o[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        state_o[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    end

endmodule

// File: rtl/permutation_multi.sv
// ASCON permutation p^12/p^8/p^6 with internal round counter, UNROLL rounds per clock
// and a start/done handshake.
//
// state | meaning
// IDLE  | waiting for start_i; permutation_o holds the last result
// RUN   | rounds remain; advances only while enable_i is high
module permutation_multi
    import ascon_pack::*;
#(
    parameter int UNROLL = 1
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic [1:0] nb_rounds_i,
    input  logic       enable_i,
    input  type_state  permutation_i,
    output type_state  permutation_o,
    output logic       busy_o,
    output logic       done_o
);

    generate
        if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
            $error("permutation_multi: UNROLL must be 1 or 2");
        end
    endgenerate

    fsm_t       fsm_q, fsm_d;
    logic [3:0] rnd_q, rnd_d;
    type_state  st_q, st_d;
    logic       done_q, done_d;

    type_state  chain [UNROLL+1];
    logic [3:0] rnd_base;
    logic [3:0] rnd_next;

    // first pass of an operation comes straight from the input port
    assign chain[0] = (fsm_q == RUN) ? st_q : permutation_i;
    assign rnd_base = (fsm_q == RUN) ? rnd_q : first_round(nb_rounds_i);
    assign rnd_next = rnd_base + 4'(UNROLL);

    generate
        for (genvar k = 0; k < UNROLL; k++) begin : g_round
            ascon_round u_round (
                .state_i (chain[k]),
                .round_i (rnd_base + 4'(k)),
                .state_o (chain[k+1])
            );
        end
    endgenerate

    always_comb begin
        fsm_d  = fsm_q;
        rnd_d  = rnd_q;
        st_d   = st_q;
        done_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    st_d  = chain[UNROLL];
                    rnd_d = rnd_next;
                    if (rnd_next == LAST_RND) begin
                        done_d = 1'b1;
                    end else begin
                        fsm_d = RUN;
                    end
                end
            end
            RUN: begin
                if (enable_i) begin
                    st_d  = chain[UNROLL];
                    rnd_d = rnd_next;
                    if (rnd_next == LAST_RND) begin
                        fsm_d  = IDLE;
                        done_d = 1'b1;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q  <= IDLE;
            rnd_q  <= 4'd0;
            st_q   <= '0;
            done_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            rnd_q  <= rnd_d;
            st_q   <= st_d;
            done_q <= done_d;
        end
    end

    assign permutation_o = st_q;
    assign busy_o        = (fsm_q == RUN);
    assign done_o        = done_q;

endmodule

// File: tb/tb_permutation_multi.sv
// Bench for permutation_multi: UNROLL=1 and UNROLL=2 instances share stimulus and are
// compared every cycle against a spec-level model of the permutation and handshake.
module tb_permutation_multi;
    import ascon_pack::*;

    logic       clock_i = 1'b0;
    logic       resetb_i;
    logic       start_i;
    logic [1:0] nb_rounds_i;
    logic       enable_i;
    type_state  permutation_i;
    type_state  perm_o [2];
    logic       busy_o [2];
    logic       done_o [2];

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clock_i = ~clock_i;

    permutation_multi #(.UNROLL(1)) u_dut1 (
        .clock_i       (clock_i),
        .resetb_i      (resetb_i),
        .start_i       (start_i),
        .nb_rounds_i   (nb_rounds_i),
        .enable_i      (enable_i),
        .permutation_i (permutation_i),
        .permutation_o (perm_o[0]),
        .busy_o        (busy_o[0]),
        .done_o        (done_o[0])
    );

    permutation_multi #(.UNROLL(2)) u_dut2 (
        .clock_i       (clock_i),
        .resetb_i      (resetb_i),
        .start_i       (start_i),
        .nb_rounds_i   (nb_rounds_i),
        .enable_i      (enable_i),
        .permutation_i (permutation_i),
        .permutation_o (perm_o[1]),
        .busy_o        (busy_o[1]),
        .done_o        (done_o[1])
    );

    // ---------------- reference model ----------------
    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [7:0] rc_fn(input int r);
        logic [3:0] lo;
        lo = 4'(r);
        return {~lo, lo};
    endfunction

    function automatic int a_of(input logic [1:0] nb);
        case (nb)
            2'b01:   return 8;
            2'b10:   return 6;
            default: return 12;
        endcase
    endfunction

    function automatic type_state rnd_fn(input type_state s, input int r);
        logic [63:0] x [5];
        logic [63:0] t [5];
        type_state o;
        for (int i = 0; i < 5; i++) x[i] = s[i];
        x[2] ^= {56'h0, rc_fn(r)};
        x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
        for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i + 1) % 5];
        for (int i = 0; i < 5; i++) x[i] ^= t[(i + 1) % 5];
        x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
        o[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
        o[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
        o[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
        o[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
        o[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
        return o;
    endfunction

    function automatic type_state perm_fn(input type_state s, input int a);
        type_state v;
        v = s;
        for (int r = 12 - a; r < 12; r++) v = rnd_fn(v, r);
        return v;
    endfunction

    // cycle behaviour: how many of the a rounds each DUT has done so far
    type_state m_st   [2];
    type_state m_in   [2];
    bit        m_busy [2];
    bit        m_done [2];
    int        m_a    [2];
    int        m_n    [2];

    always @(posedge clock_i or negedge resetb_i) begin : mdl
        int u;
        int n;
        for (int d = 0; d < 2; d++) begin
            u = d + 1;
            if (!resetb_i) begin
                m_st[d]   <= '0;
                m_busy[d] <= 1'b0;
                m_done[d] <= 1'b0;
                m_n[d]    <= 0;
            end else if (!m_busy[d]) begin
                m_done[d] <= 1'b0;
                if (start_i) begin
                    n = (u < a_of(nb_rounds_i)) ? u : a_of(nb_rounds_i);
                    m_in[d]   <= permutation_i;
                    m_a[d]    <= a_of(nb_rounds_i);
                    m_n[d]    <= n;
                    m_st[d]   <= partial(permutation_i, a_of(nb_rounds_i), n);
                    m_busy[d] <= (n < a_of(nb_rounds_i));
                    m_done[d] <= (n == a_of(nb_rounds_i));
                end
            end else if (enable_i) begin
                n = m_n[d] + u;
                m_n[d]    <= n;
                m_st[d]   <= partial(m_in[d], m_a[d], n);
                m_busy[d] <= (n < m_a[d]);
                m_done[d] <= (n == m_a[d]);
            end else begin
                m_done[d] <= 1'b0;
            end
        end
    end

    // first n rounds of p^a applied to s
    function automatic type_state partial(input type_state s, input int a, input int n);
        type_state v;
        v = s;
        for (int r = 12 - a; r < 12 - a + n; r++) v = rnd_fn(v, r);
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock_i) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk(d ? "cyc_perm_u2" : "cyc_perm_u1", perm_o[d], m_st[d]);
                chk(d ? "cyc_busy_u2" : "cyc_busy_u1", 320'(busy_o[d]), 320'(m_busy[d]));
                chk(d ? "cyc_done_u2" : "cyc_done_u1", 320'(done_o[d]), 320'(m_done[d]));
            end
        end
    end

    // starts one operation from a negedge and waits for both instances to finish
    task automatic run_op(input string name, input logic [1:0] nb, input type_state din,
                          input int exp1, input int exp2, input int exp_busy1,
                          input int stall_at, input int stall_len, input int ign_at,
                          input bit chain, input logic [1:0] cnb, input type_state cdin);
        int k;
        int lat [2];
        int b1;
        type_state ref_res;
        ref_res = perm_fn(din, a_of(nb));
        start_i = 1'b1;
        nb_rounds_i = nb;
        permutation_i = din;
        k = 0; lat[0] = 0; lat[1] = 0; b1 = 0;
        while ((lat[0] == 0 || lat[1] == 0) && k < 60) begin
            @(negedge clock_i);
            k++;
            if (k == 1) start_i = 1'b0;
            if (ign_at > 0 && k == ign_at) begin
                start_i = 1'b1;
                nb_rounds_i = P6;
                permutation_i = ~din;
            end
            if (ign_at > 0 && k == ign_at + 1) start_i = 1'b0;
            if (stall_len > 0 && k == stall_at) enable_i = 1'b0;
            if (stall_len > 0 && k == stall_at + stall_len) enable_i = 1'b1;
            if (busy_o[0]) b1++;
            for (int d = 0; d < 2; d++) begin
                if (done_o[d] && lat[d] == 0) begin
                    lat[d] = k;
                    chk({name, d ? "_res_u2" : "_res_u1"}, perm_o[d], ref_res);
                end
            end
            if (chain && done_o[0]) begin
                start_i = 1'b1;
                nb_rounds_i = cnb;
                permutation_i = cdin;
            end
        end
        chk({name, "_lat_u1"}, 320'(lat[0]), 320'(exp1));
        chk({name, "_lat_u2"}, 320'(lat[1]), 320'(exp2));
        if (exp_busy1 > 0) chk({name, "_busy_cycles_u1"}, 320'(b1), 320'(exp_busy1));
    endtask

    type_state d_a, d_b, z_exp, zero_st;

    initial begin
        resetb_i = 1'b0;
        start_i = 1'b0;
        nb_rounds_i = P12;
        enable_i = 1'b1;
        permutation_i = '0;
        zero_st = '0;
        d_a[0] = 64'h00001000808C0001;
        d_a[1] = 64'h6CB10AD9CA912F80;
        d_a[2] = 64'h691AED630E81901F;
        d_a[3] = 64'h0C4C36A20853217C;
        d_a[4] = 64'h46487B3E06D9D7A8;
        d_b[0] = 64'h0123456789ABCDEF;
        d_b[1] = 64'hFEDCBA9876543210;
        d_b[2] = 64'h0F1E2D3C4B5A6978;
        d_b[3] = 64'h8877665544332211;
        d_b[4] = 64'hDEADBEEFCAFEF00D;

        // hand-derived values pinning the model
        chk("pin_rc0", 320'(rc_fn(0)), 320'(8'hF0));
        chk("pin_rc1", 320'(rc_fn(1)), 320'(8'hE1));
        chk("pin_rc_p8", 320'(rc_fn(12 - a_of(P8))), 320'(8'hB4));
        chk("pin_rc_p6", 320'(rc_fn(12 - a_of(P6))), 320'(8'h96));
        chk("pin_rc11", 320'(rc_fn(11)), 320'(8'h4B));
        chk("pin_a_11", 320'(a_of(2'b11)), 320'(12));
        z_exp[0] = 64'h000964B00000004B;
        z_exp[1] = 64'h0000000096000213;
        z_exp[2] = 64'h53FFFFFFFFFFFF90;
        z_exp[3] = 64'h12E580000000004B;
        z_exp[4] = 64'h0000000000000000;
        chk("pin_round11_zero", rnd_fn(zero_st, 11), z_exp);

        // reset held for two cycles, then idle with no start
        repeat (2) @(negedge clock_i);
        resetb_i = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge clock_i);
        for (int d = 0; d < 2; d++) begin
            chk("rst_perm", perm_o[d], '0);
            chk("rst_busy", 320'(busy_o[d]), 320'(0));
            chk("rst_done", 320'(done_o[d]), 320'(0));
        end

        run_op("p12",     P12,   d_a, 12, 6, 11, 0, 0, 0, 1'b0, P12, d_a);
        run_op("p8",      P8,    d_a, 8,  4, 7,  0, 0, 0, 1'b0, P12, d_a);
        run_op("p6",      P6,    d_b, 6,  3, 5,  0, 0, 0, 1'b0, P12, d_a);
        run_op("p12_nb3", 2'b11, d_b, 12, 6, 11, 0, 0, 0, 1'b0, P12, d_a);
        run_op("stall",   P6,    d_a, 9,  6, 8,  1, 3, 0, 1'b0, P12, d_a);
        run_op("ignore",  P12,   d_b, 12, 6, 11, 0, 0, 2, 1'b0, P12, d_a);
        run_op("b2b_1",   P8,    d_a, 8,  4, 0,  0, 0, 0, 1'b1, P6,  d_b);
        run_op("b2b_2",   P6,    d_b, 6,  3, 0,  0, 0, 0, 1'b0, P12, d_a);

        // reset in the middle of an operation clears outputs without a clock edge
        start_i = 1'b1;
        nb_rounds_i = P12;
        permutation_i = d_a;
        @(negedge clock_i);
        start_i = 1'b0;
        repeat (4) @(negedge clock_i);
        #2;
        resetb_i = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("midrst_perm", perm_o[d], '0);
            chk("midrst_busy", 320'(busy_o[d]), 320'(0));
            chk("midrst_done", 320'(done_o[d]), 320'(0));
        end
        @(negedge clock_i);
        resetb_i = 1'b1;
        run_op("after_rst", P8, d_b, 8, 4, 7, 0, 0, 0, 1'b0, P12, d_a);

        repeat (2) @(negedge clock_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
